// File: rtl/operand_pair_sequencer_if.sv
// Handshake and operand bus between the pair feeder, its upstream source and the logical-operator block.
interface operand_pair_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_a;
  logic [WIDTH-1:0]       in_b;
  logic [WIDTH-1:0]       a_out;
  logic [WIDTH-1:0]       b_out;
  logic                   pair_valid;
  logic                   sample_stb;
  logic [$clog2(DEPTH):0] level;
  logic                   busy;

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready, a_out, b_out, pair_valid, sample_stb, level, busy
  );

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready, a_out, b_out, pair_valid, sample_stb, level, busy
  );
endinterface

// File: rtl/operand_pair_sequencer.sv
// Buffers operand pairs and presents each one for HOLD_CYCLES cycles; a pair pushed into an idle, empty unit appears one edge later.
// Upstream is stalled by in_ready, which follows the registered full flag, so a same-cycle pop does not reopen the FIFO.
module operand_pair_sequencer #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 5
) (
  input logic                    clk,
  input logic                    rst,
  operand_pair_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [0:0]    IDLE       = 1'b0;
  localparam logic [0:0]    HOLD       = 1'b1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic hold_done;

  assign full      = (level_q == LEVEL_FULL);
  assign empty     = (level_q == '0);
  assign hold_done = (state == HOLD) && (cnt == '0);
  assign push      = bus.in_valid && bus.in_ready;
  // Loading the next pair on the last hold cycle gives gap-free streaming.
  assign pop       = !empty && ((state == IDLE) || hold_done);

  assign bus.in_ready   = !full && !rst;
  assign bus.a_out      = a_q;
  assign bus.b_out      = b_q;
  assign bus.pair_valid = (state == HOLD);
  assign bus.sample_stb = hold_done && !rst;
  assign bus.level      = level_q;
  assign bus.busy       = (state == HOLD) || !empty;

  // Storage needs no reset; push is already blocked while rst is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_a;
      mem_b[wr_ptr] <= bus.in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (pop) begin
        a_q    <= mem_a[rd_ptr];
        b_q    <= mem_b[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
        cnt    <= CNT_RELOAD;
        state  <= HOLD;
      end else if (hold_done) begin
        state <= IDLE;
      end else if (state == HOLD) begin
        cnt <= cnt - 1'b1;
      end

      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_operand_pair_sequencer.sv
// Self-checking bench: scoreboard of pushed pairs checked at every sample strobe, plus directed timing checks.
module tb_operand_pair_sequencer;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int HOLD  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  operand_pair_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  operand_pair_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  logic [2*WIDTH-1:0] sb[$];
  logic [2*WIDTH-1:0] exp_pair;
  int n_stb = 0;
  int last_stb = -1;
  int stream_prev = -1;
  int pv_low = 0;
  bit stream_on = 1'b0;

  always @(negedge clk) begin
    if (bus.sample_stb === 1'b1) begin
      n_stb++;
      if (sb.size() == 0) begin
        check("stb_unexpected", 32'(bus.sample_stb), 32'd0);
      end else begin
        exp_pair = sb.pop_front();
        check("stb_a_out", 32'(bus.a_out), 32'(exp_pair[2*WIDTH-1:WIDTH]));
        check("stb_b_out", 32'(bus.b_out), 32'(exp_pair[WIDTH-1:0]));
      end
      if (stream_on && stream_prev >= 0) check("stb_gap", 32'(cyc - stream_prev), 32'(HOLD));
      if (stream_on) stream_prev = cyc;
      last_stb = cyc;
    end
    if (stream_on && bus.pair_valid !== 1'b1) pv_low++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int acc);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    acc          = -1;
    for (int i = 0; i < 64; i++) begin
      if (bus.in_ready === 1'b1) begin
        tick();
        acc = cyc;
        sb.push_back({a, b});
        break;
      end
      tick();
    end
    if (acc < 0) check("send_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (bus.busy === 1'b0) break;
      tick();
    end
    if (i == budget) check("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  task automatic wait_stb(input int target, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (n_stb >= target) break;
      tick();
    end
    if (i == budget) check("stb_timeout", 32'(n_stb), 32'(target));
  endtask

  initial begin
    int k;
    int t;
    int a0;
    int base;
    logic [WIDTH-1:0] xa;
    logic [WIDTH-1:0] za;
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    xa = 4'bxxxx;
    za = 4'bzzzz;

    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    tick();
    check("rst_in_ready_low", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_a_out", 32'(bus.a_out), 32'd0);
    check("rst_b_out", 32'(bus.b_out), 32'd0);
    check("rst_pair_valid", 32'(bus.pair_valid), 32'd0);
    check("rst_sample_stb", 32'(bus.sample_stb), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    // Single pair: one-edge load latency, one strobe HOLD cycles later, outputs retained.
    base = n_stb;
    send(4'b0010, 4'b0000, k);
    tick();
    check("t2_a_out", 32'(bus.a_out), 32'h2);
    check("t2_b_out", 32'(bus.b_out), 32'h0);
    check("t2_pair_valid", 32'(bus.pair_valid), 32'd1);
    check("t2_level", 32'(bus.level), 32'd0);
    wait_idle(20);
    check("t2_stb_count", 32'(n_stb - base), 32'd1);
    check("t2_stb_cycle", 32'(last_stb - k), 32'(HOLD));
    check("t2_pv_after", 32'(bus.pair_valid), 32'd0);
    check("t2_a_retained", 32'(bus.a_out), 32'h2);

    // Fill FIFO behind a live pair, then a held fifth pair waits for the first pop.
    send(4'h1, 4'h1, a0);
    send(4'h3, 4'h4, t);
    send(4'h5, 4'h6, t);
    send(4'h7, 4'h8, t);
    send(4'h9, 4'hA, t);
    check("t3_level_full", 32'(bus.level), 32'd4);
    check("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
    send(4'hF, 4'hF, t);
    check("t3_accept_cycle", 32'(t - a0), 32'd7);
    wait_idle(100);
    check("t3_sb_drained", 32'(sb.size()), 32'd0);

    // Streaming six pairs: continuous pair_valid, strobes HOLD apart, push order kept.
    base        = n_stb;
    pv_low      = 0;
    stream_prev = -1;
    for (int i = 0; i < 6; i++) begin
      av = 4'(i * 3 + 1);
      bv = 4'(15 - i);
      send(av, bv, t);
      if (i == 1) stream_on = 1'b1;
    end
    wait_stb(base + 6, 200);
    stream_on = 1'b0;
    check("t4_stb_count", 32'(n_stb - base), 32'd6);
    check("t4_pv_low", 32'(pv_low), 32'd0);
    wait_idle(50);

    // Reset mid-hold with three pairs queued discards everything.
    send(4'h2, 4'h3, k);
    send(4'h4, 4'h5, t);
    send(4'h6, 4'h7, t);
    send(4'h8, 4'h9, t);
    check("t5_level_before", 32'(bus.level), 32'd3);
    rst = 1'b1;
    sb.delete();
    base = n_stb;
    tick();
    check("t5_level", 32'(bus.level), 32'd0);
    check("t5_pair_valid", 32'(bus.pair_valid), 32'd0);
    check("t5_a_out", 32'(bus.a_out), 32'd0);
    check("t5_b_out", 32'(bus.b_out), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    repeat (10) tick();
    check("t5_no_strobe", 32'(n_stb - base), 32'd0);

    // Unknown and high-impedance operands pass through bit-exact.
    base = n_stb;
    send(xa, 4'b0001, k);
    send(za, za, t);
    check("t6_a_x", 32'(bus.a_out), 32'(xa));
    check("t6_b_1", 32'(bus.b_out), 32'h1);
    wait_stb(base + 1, 20);
    check("t6_stb_cycle", 32'(last_stb - k), 32'(HOLD));
    tick();
    check("t6_a_z", 32'(bus.a_out), 32'(za));
    check("t6_b_z", 32'(bus.b_out), 32'(za));
    wait_idle(30);
    check("t6_stb_count", 32'(n_stb - base), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
